// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding.
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA = 2'd2;
  localparam logic [1:0] RX_STOP = 2'd3;
endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchronizer for the idle-high serial line.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver with one-deep output register, framing and overrun flags.
module uart_rx import uart_pkg::*; #(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_edge,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 read_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] TOP = IW'(DATA_BITS - 1);
  logic rx_s, stale, ack, commit, take;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] sh;
  rx_sync u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  // a held read_ack only acknowledges bytes present before it was raised
  assign ack = read_ack && !stale;
  assign commit = sample_edge && state == RX_STOP && cnt == LAST;
  assign take = !valid || ack;
  assign busy = state != RX_IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RX_IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else if (sample_edge) begin
      case (state)
        RX_IDLE: if (!rx_s) begin
          state <= RX_START;
          cnt <= '0;
        end
        RX_START: if (cnt == HALF) begin
          state <= rx_s ? RX_IDLE : RX_DATA;
          cnt <= '0;
          idx <= '0;
        end else cnt <= cnt + 1'b1;
        RX_DATA: if (cnt == LAST) begin
          sh <= {rx_s, sh[DATA_BITS-1:1]};
          cnt <= '0;
          idx <= idx + 1'b1;
          if (idx == TOP) state <= RX_STOP;
        end else cnt <= cnt + 1'b1;
        default: if (cnt == LAST) begin
          state <= RX_IDLE;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      stale <= 1'b0;
    end else begin
      stale <= read_ack && (stale || (commit && take));
      if (commit && take) begin
        data <= sh;
        valid <= 1'b1;
        frame_err <= ~rx_s;
      end else if (commit) overrun <= 1'b1;
      else if (ack && valid) begin
        valid <= 1'b0;
        overrun <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames at 16 strobes per bit and checks outputs against a behavioural output-register model.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx = 1'b1;
  logic read_ack = 1'b0;
  logic [1:0] div = 2'd0;
  logic sample_edge;
  logic [7:0] data;
  logic valid, frame_err, overrun, busy;
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] m_data = 8'h00;
  logic m_valid = 1'b0;
  logic m_fe = 1'b0;
  logic m_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign sample_edge = div == 2'd3;

  uart_rx dut (
    .clk(clk), .rst(rst), .sample_edge(sample_edge), .rx(rx),
    .data(data), .valid(valid), .read_ack(read_ack),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_data"}, 32'(data), 32'(m_data));
    check({tag, "_valid"}, 32'(valid), 32'(m_valid));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(m_fe));
    check({tag, "_overrun"}, 32'(overrun), 32'(m_ov));
  endtask

  task automatic strobe();
    do @(negedge clk); while (!sample_edge);
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    read_ack = 1'b1;
    @(negedge clk);
    read_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ov = 1'b0;
    end
    check_out("ack");
  endtask

  // hold > 0 raises read_ack on the mid-stop-bit strobe cycle for that many clocks
  task automatic send(input logic [7:0] b, input logic stop, input int hold);
    strobe();
    rx = 1'b0;
    repeat (16) strobe();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) strobe();
    end
    rx = stop;
    repeat (8) strobe();
    if (hold > 0) begin
      do @(negedge clk); while (!sample_edge);
      read_ack = 1'b1;
      @(posedge clk);
      #1;
    end else strobe();
    if (!m_valid || hold > 0) begin
      m_data = b;
      m_valid = 1'b1;
      m_fe = ~stop;
    end else m_ov = 1'b1;
    check("busy_commit", 32'(busy), 32'd0);
    check_out("commit");
    if (hold > 0) begin
      repeat (hold - 1) begin
        @(posedge clk);
        #1;
      end
      read_ack = 1'b0;
    end
    repeat (7) strobe();
    rx = 1'b1;
    repeat (6) strobe();
    check("busy_idle", 32'(busy), 32'd0);
    check_out("after");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic stop;
    int hold;
    #2 rst = 1'b1;
    #20;
    check("rst_busy", 32'(busy), 32'd0);
    check_out("rst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) strobe();
    send(8'h55, 1'b1, 0);
    ack_pulse();
    send(8'hA3, 1'b0, 0);
    ack_pulse();
    strobe();
    rx = 1'b0;
    repeat (4) strobe();
    check("glitch_busy_hi", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (10) strobe();
    check("glitch_busy_lo", 32'(busy), 32'd0);
    check_out("glitch");
    send(8'h11, 1'b1, 0);
    send(8'h22, 1'b1, 0);
    ack_pulse();
    send(8'h11, 1'b1, 0);
    send(8'h22, 1'b1, 1);
    send(8'h5A, 1'b1, 0);
    strobe();
    rx = 1'b0;
    repeat (16) strobe();
    rx = 1'b1;
    repeat (56) strobe();
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    m_data = 8'h00;
    m_valid = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check_out("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) strobe();
    send(8'h0F, 1'b1, 0);
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom);
      stop = $urandom_range(0, 7) != 0;
      hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      send(b, stop, hold);
      if ($urandom_range(0, 1) == 1) ack_pulse();
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
